// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RV32I core: opcodes, FSM states, ALU ops
// and the OP/OP-IMM function decoder.
package cpu_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, HALT} state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef struct packed {
    logic    legal;
    alu_op_t op;
  } alu_dec_t;

  // For OP-IMM, funct7 is immediate data except on shifts, where it selects SRL/SRA.
  function automatic alu_dec_t decode_alu(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic is_imm);
    alu_dec_t d;
    logic     alt;
    alt = (f7 == 7'b0100000);
    d.legal = is_imm ? 1'b1 : ((f7 == 7'b0) || (alt && (f3 == 3'b000 || f3 == 3'b101)));
    if (is_imm && f3 == 3'b001) d.legal = (f7 == 7'b0);
    if (is_imm && f3 == 3'b101) d.legal = (f7 == 7'b0) || alt;
    case (f3)
      3'b000:  d.op = (!is_imm && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  d.op = ALU_SLL;
      3'b010:  d.op = ALU_SLT;
      3'b011:  d.op = ALU_SLTU;
      3'b100:  d.op = ALU_XOR;
      3'b101:  d.op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  d.op = ALU_OR;
      default: d.op = ALU_AND;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational 32-bit ALU; the compare flags are independent of op so branches can
// use them directly.
module cpu_alu
  import cpu_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        lt,
  output logic        ltu,
  output logic        eq
);

  assign lt  = $signed(a) < $signed(b);
  assign ltu = a < b;
  assign eq  = (a == b);

  always_comb begin
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'b0, lt};
      ALU_SLTU: y = {31'b0, ltu};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle RV32I/RV32E core: FETCH -> EXEC -> [MEM] -> WB with req/ack memory ports.
// Define CPU_PERF_COUNTERS_EN to add cycle_count/instret_count outputs.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        halted
`ifdef CPU_PERF_COUNTERS_EN
  ,
  output logic [63:0] cycle_count,
  output logic [63:0] instret_count
`endif
);

  localparam int RW = $clog2(NREGS);

  state_t      state_q, state_d;
  logic        run_q;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
  logic [31:0] regs_q [NREGS];

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_val, rs2_val, pc_plus4;

  assign opcode   = ir_q[6:0];
  assign rd       = ir_q[11:7];
  assign funct3   = ir_q[14:12];
  assign rs1      = ir_q[19:15];
  assign rs2      = ir_q[24:20];
  assign funct7   = ir_q[31:25];
  assign imm_i    = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s    = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b    = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u    = {ir_q[31:12], 12'b0};
  assign imm_j    = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign rs1_val  = regs_q[rs1[RW-1:0]];
  assign rs2_val  = regs_q[rs2[RW-1:0]];
  assign pc_plus4 = pc_q + 32'd4;

  alu_op_t     alu_op;
  alu_dec_t    alu_dec;
  logic [31:0] alu_a, alu_b, alu_y, next_pc, wb_data;
  logic        alu_lt, alu_ltu, alu_eq;
  logic        legal, is_mem, use_rs1, use_rs2, use_rd, taken, illegal, rf_we;

  cpu_alu u_alu (
    .op  (alu_op),
    .a   (alu_a),
    .b   (alu_b),
    .y   (alu_y),
    .lt  (alu_lt),
    .ltu (alu_ltu),
    .eq  (alu_eq)
  );

  // NOTE: every signal written in an always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    alu_op  = ALU_ADD;
    alu_a   = rs1_val;
    alu_b   = imm_i;
    legal   = 1'b0;
    is_mem  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    alu_dec = decode_alu(funct3, funct7, opcode == OP_IMM);
    case (opcode)
      OP_LUI:    begin legal = 1'b1; use_rd = 1'b1; alu_a = '0;   alu_b = imm_u; end
      OP_AUIPC:  begin legal = 1'b1; use_rd = 1'b1; alu_a = pc_q; alu_b = imm_u; end
      OP_JAL:    begin legal = 1'b1; use_rd = 1'b1; end
      OP_JALR:   begin legal = (funct3 == 3'b000); use_rd = 1'b1; use_rs1 = 1'b1; end
      OP_BRANCH: begin
        legal = (funct3[2:1] != 2'b01); use_rs1 = 1'b1; use_rs2 = 1'b1; alu_b = rs2_val;
      end
      OP_LOAD:   begin
        legal = (funct3 == 3'b010); is_mem = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OP_STORE:  begin
        legal = (funct3 == 3'b010); is_mem = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        alu_b = imm_s;
      end
      OP_IMM:    begin
        legal = alu_dec.legal; alu_op = alu_dec.op; use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OP_OP:     begin
        legal = alu_dec.legal; alu_op = alu_dec.op; use_rd = 1'b1; use_rs1 = 1'b1;
        use_rs2 = 1'b1; alu_b = rs2_val;
      end
      default:   legal = 1'b0;
    endcase
    // With 16 registers, index bit 4 set on any field the instruction uses is illegal.
    illegal = !legal || ((NREGS < 32) &&
              ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4])));

    case (funct3)
      3'b000:  taken = alu_eq;
      3'b001:  taken = !alu_eq;
      3'b100:  taken = alu_lt;
      3'b101:  taken = !alu_lt;
      3'b110:  taken = alu_ltu;
      3'b111:  taken = !alu_ltu;
      default: taken = 1'b0;
    endcase

    next_pc = pc_plus4;
    wb_data = alu_y;
    case (opcode)
      OP_JAL:    begin next_pc = pc_q + imm_j;          wb_data = pc_plus4; end
      OP_JALR:   begin next_pc = alu_y & ~32'd1;        wb_data = pc_plus4; end
      OP_BRANCH: if (taken) next_pc = pc_q + imm_b;
      OP_LOAD:   wb_data = mdr_q;
      default:   next_pc = pc_plus4;
    endcase
    rf_we = (state_q == WB) && (opcode != OP_STORE) && (opcode != OP_BRANCH) && (rd != 5'd0);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    case (state_q)
      FETCH: if (imem_req && imem_ack) begin
        ir_d    = imem_rdata;
        state_d = EXEC;
      end
      EXEC:  state_d = illegal ? HALT : (is_mem ? MEM : WB);
      MEM:   if (dmem_ack) begin
        mdr_d   = dmem_rdata;
        state_d = WB;
      end
      WB:    begin
        pc_d    = next_pc;
        state_d = FETCH;
      end
      default: state_d = HALT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      run_q   <= 1'b0;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
    end
  end

  // NOTE: registers must read 0 after reset, so the file is reset flop by flop; this
  // deliberately rules out mapping it onto a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rd[RW-1:0]] <= wb_data;
    end
  end

  // run_q holds off the first fetch until one edge after reset release.
  assign imem_req   = run_q && (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == MEM);
  assign dmem_we    = dmem_req && (opcode == OP_STORE);
  assign dmem_addr  = alu_y;
  assign dmem_wdata = rs2_val;
  assign halted     = (state_q == HALT);

`ifdef CPU_PERF_COUNTERS_EN
  logic [63:0] cycle_q, instret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != HALT) cycle_q   <= cycle_q + 64'd1;
      if (state_q == WB)   instret_q <= instret_q + 64'd1;
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: runs a small program from wait-stated memory models
// and compares fetch order, timing, memory traffic, halt and reset behaviour.
module tb_multicycle_cpu;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int dwait   = 3;
  int dcnt    = 0;

  logic [31:0] imem [logic [31:0]];
  logic [31:0] dmem [64];
  logic [31:0] fetch_addr[$];
  int          fetch_cyc[$];
  logic [31:0] acc_addr[$], acc_data[$];
  logic        acc_we[$], acc_stable[$];
  logic [31:0] d_a, d_wd;
  logic        d_we, d_stable;

  localparam logic [31:0] EXP_FETCH [23] = '{
    32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h120, 32'h124,
    32'h040, 32'h060, 32'h064, 32'h068, 32'h06C, 32'h070, 32'h074, 32'h078,
    32'h07C, 32'h080, 32'h084, 32'h088, 32'h08C, 32'h090, 32'h094};
  localparam logic [31:0] EXP_ADDR [10] = '{
    32'd8, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28, 32'd32, 32'd36, 32'd40};
  localparam logic [31:0] EXP_DATA [10] = '{
    32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h44, 32'h128,
    32'hFFFF_FF1C, 32'hF800_0000, 32'h107C, 32'h1, 32'h1};
  localparam logic EXP_WE [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  multicycle_cpu #(.RESET_PC(32'h100), .NREGS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return imem.exists(a) ? imem[a] : 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responders: sample requests on the falling edge, answer for the next rising edge.
  initial begin
    imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    d_a = '0; d_wd = '0; d_we = 1'b0; d_stable = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (imem_req) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_word(imem_addr);
        fetch_addr.push_back(imem_addr);
        fetch_cyc.push_back(cyc);
      end else begin
        imem_ack = 1'b0;
      end
      if (dmem_req) begin
        if (dcnt == 0) begin
          d_a = dmem_addr; d_we = dmem_we; d_wd = dmem_wdata; d_stable = 1'b1;
        end else if (dmem_addr !== d_a || dmem_we !== d_we || dmem_wdata !== d_wd) begin
          d_stable = 1'b0;
        end
        if (dcnt >= dwait) begin
          dmem_ack = 1'b1;
          acc_addr.push_back(dmem_addr);
          acc_we.push_back(dmem_we);
          acc_stable.push_back(d_stable);
          if (dmem_we) begin
            dmem[dmem_addr[7:2]] = dmem_wdata;
            acc_data.push_back(dmem_wdata);
          end else begin
            dmem_rdata = dmem[dmem_addr[7:2]];
            acc_data.push_back(dmem_rdata);
          end
          dcnt = 0;
        end else begin
          dmem_ack = 1'b0;
          dcnt++;
        end
      end else begin
        dmem_ack = 1'b0;
        dcnt = 0;
      end
    end
  end

  initial begin
    int k;
    reset = 1'b0;
    for (int i = 0; i < 64; i++) dmem[i] = '0;
    imem[32'h100] = enc_i(12'd5,      5'd0, 3'b000, 5'd1, 7'b0010011);  // addi x1,x0,5
    imem[32'h104] = enc_i(12'hFF9,    5'd1, 3'b000, 5'd2, 7'b0010011);  // addi x2,x1,-7
    imem[32'h108] = enc_s(12'd8,      5'd2, 5'd0);                       // sw x2,8(x0)
    imem[32'h10C] = enc_i(12'd8,      5'd0, 3'b010, 5'd3, 7'b0000011);  // lw x3,8(x0)
    imem[32'h110] = enc_s(12'd12,     5'd3, 5'd0);                       // sw x3,12(x0)
    imem[32'h114] = enc_b(13'd12,     5'd1, 5'd2, 3'b100);               // blt x2,x1,+12
    imem[32'h120] = enc_b(13'd12,     5'd1, 5'd2, 3'b110);               // bltu x2,x1,+12
    imem[32'h124] = enc_i(12'h041,    5'd0, 3'b000, 5'd4, 7'b1100111);  // jalr x4,0x41(x0)
    imem[32'h040] = enc_j(21'h20,     5'd1);                             // jal x1,+0x20
    imem[32'h060] = enc_s(12'd16,     5'd1, 5'd0);                       // sw x1,16(x0)
    imem[32'h064] = enc_s(12'd20,     5'd4, 5'd0);                       // sw x4,20(x0)
    imem[32'h068] = enc_r(7'b0100000, 5'd4, 5'd1, 3'b000, 5'd5);         // sub x5,x1,x4
    imem[32'h06C] = enc_s(12'd24,     5'd5, 5'd0);                       // sw x5,24(x0)
    imem[32'h070] = {20'h80000, 5'd6, 7'b0110111};                       // lui x6,0x80000
    imem[32'h074] = enc_i(12'h404,    5'd6, 3'b101, 5'd7, 7'b0010011);  // srai x7,x6,4
    imem[32'h078] = enc_s(12'd28,     5'd7, 5'd0);                       // sw x7,28(x0)
    imem[32'h07C] = {20'h00001, 5'd8, 7'b0010111};                       // auipc x8,1
    imem[32'h080] = enc_s(12'd32,     5'd8, 5'd0);                       // sw x8,32(x0)
    imem[32'h084] = enc_r(7'b0,       5'd1, 5'd2, 3'b010, 5'd9);         // slt x9,x2,x1
    imem[32'h088] = enc_r(7'b0,       5'd2, 5'd1, 3'b011, 5'd10);        // sltu x10,x1,x2
    imem[32'h08C] = enc_s(12'd36,     5'd9, 5'd0);                       // sw x9,36(x0)
    imem[32'h090] = enc_s(12'd40,     5'd10, 5'd0);                      // sw x10,40(x0)

    repeat (2) @(negedge clk);
    check("rst_imem_req", imem_req, 32'd0);
    check("rst_dmem_req", dmem_req, 32'd0);
    check("rst_dmem_we",  dmem_we,  32'd0);
    check("rst_halted",   halted,   32'd0);
    check("rst_pc",       imem_addr, 32'h100);

    @(negedge clk);
    reset = 1'b1;
    #1 check("req_low_at_release", imem_req, 32'd0);
    @(posedge clk);
    #1 check("first_req", imem_req, 32'd1);
    check("first_addr", imem_addr, 32'h100);

    k = 0;
    while (acc_addr.size() < 2 && k < 200) begin @(negedge clk); k++; end
    check("wait_two_accesses", 32'(acc_addr.size() >= 2), 32'd1);
    dwait = 0;

    k = 0;
    while (!halted && k < 500) begin @(negedge clk); k++; end
    check("halt_reached", halted, 32'd1);
    repeat (10) @(negedge clk);

    check("fetch_count", fetch_addr.size(), 32'd23);
    for (int i = 0; i < 23; i++)
      check($sformatf("fetch_addr[%0d]", i), (i < fetch_addr.size()) ? fetch_addr[i] : 32'hx,
            EXP_FETCH[i]);
    check("addi_spacing",  fetch_cyc[1]  - fetch_cyc[0],  32'd3);
    check("sw_wait_spacing", fetch_cyc[3] - fetch_cyc[2], 32'd7);
    check("lw_wait_spacing", fetch_cyc[4] - fetch_cyc[3], 32'd7);
    check("branch_spacing", fetch_cyc[6] - fetch_cyc[5],  32'd3);
    check("sw_spacing",    fetch_cyc[10] - fetch_cyc[9],  32'd4);

    check("access_count", acc_addr.size(), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("acc_addr[%0d]", i), (i < acc_addr.size()) ? acc_addr[i] : 32'hx,
            EXP_ADDR[i]);
      check($sformatf("acc_we[%0d]", i), (i < acc_we.size()) ? acc_we[i] : 1'bx, EXP_WE[i]);
      check($sformatf("acc_data[%0d]", i), (i < acc_data.size()) ? acc_data[i] : 32'hx,
            EXP_DATA[i]);
      check($sformatf("acc_stable[%0d]", i), (i < acc_stable.size()) ? acc_stable[i] : 1'bx,
            32'd1);
    end

    check("halt_no_imem_req", imem_req, 32'd0);
    check("halt_no_dmem_req", dmem_req, 32'd0);
    check("halt_sticky", halted, 32'd1);

    @(negedge clk);
    reset = 1'b0;
    #1 check("rst2_halted", halted, 32'd0);
    check("rst2_imem_req", imem_req, 32'd0);
    check("rst2_pc", imem_addr, 32'h100);
    fetch_addr.delete();
    fetch_cyc.delete();
    dwait = 10;
    @(negedge clk);
    reset = 1'b1;

    k = 0;
    while (fetch_addr.size() < 1 && k < 20) begin @(negedge clk); k++; end
    check("restart_fetch", (fetch_addr.size() > 0) ? fetch_addr[0] : 32'hx, 32'h100);

    k = 0;
    while (!dmem_req && k < 50) begin @(negedge clk); k++; end
    check("mid_dmem_req", dmem_req, 32'd1);
    check("mid_dmem_addr", dmem_addr, 32'd8);
    check("mid_dmem_wdata", dmem_wdata, 32'hFFFF_FFFE);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("abort_dmem_req", dmem_req, 32'd0);
    check("abort_dmem_we", dmem_we, 32'd0);
    check("abort_imem_req", imem_req, 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_access", acc_addr.size(), 32'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
